// File: rtl/peripheral_arbiter_master_ahb3.sv
// rtl/peripheral_arbiter_master_ahb3.sv - round-robin AHB3-Lite master arbiter with lock handling and hold watchdog
module peripheral_arbiter_master_ahb3 #(
  parameter int MASTERS    = 2,
  parameter int HADDR_SIZE = 16,
  parameter int HDATA_SIZE = 32,
  parameter int MAX_HOLD   = 64
) (
  input  logic                             HRESETn,
  input  logic                             HCLK,

  input  logic [MASTERS-1:0]               mst_HSEL,
  input  logic [MASTERS*HADDR_SIZE-1:0]    mst_HADDR,
  input  logic [MASTERS*HDATA_SIZE-1:0]    mst_HWDATA,
  input  logic [MASTERS-1:0]               mst_HWRITE,
  input  logic [MASTERS*3-1:0]             mst_HSIZE,
  input  logic [MASTERS*3-1:0]             mst_HBURST,
  input  logic [MASTERS*4-1:0]             mst_HPROT,
  input  logic [MASTERS*2-1:0]             mst_HTRANS,
  input  logic [MASTERS-1:0]               mst_HMASTLOCK,
  output logic [MASTERS-1:0]               mst_HREADY,
  output logic [HDATA_SIZE-1:0]            mst_HRDATA,
  output logic                             mst_HRESP,

  output logic                             HSEL,
  output logic [HADDR_SIZE-1:0]            HADDR,
  output logic [HDATA_SIZE-1:0]            HWDATA,
  input  logic [HDATA_SIZE-1:0]            HRDATA,
  output logic                             HWRITE,
  output logic [2:0]                       HSIZE,
  output logic [2:0]                       HBURST,
  output logic [3:0]                       HPROT,
  output logic [1:0]                       HTRANS,
  output logic                             HMASTLOCK,
  input  logic                             HREADY,
  input  logic                             HRESP,

  output logic [$clog2(MASTERS)-1:0]       arb_grant,
  output logic                             arb_timeout
);

  localparam int GW = $clog2(MASTERS);

  logic [GW-1:0]           g_q, g_d;
  logic [GW-1:0]           d_q, d_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;

  logic [MASTERS-1:0]      req;
  logic                    other_req;
  logic [GW-1:0]           next_owner;
  logic                    can_switch;

  logic                    own_sel;
  logic [HADDR_SIZE-1:0]   own_addr;
  logic                    own_write;
  logic [2:0]              own_size;
  logic [2:0]              own_burst;
  logic [3:0]              own_prot;
  logic [1:0]              own_trans;
  logic                    own_lock;
  logic [HDATA_SIZE-1:0]   dph_wdata;

  // Request vector: a master wants the bus when selected with NONSEQ or SEQ
  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERS; i++) begin
      req[i] = mst_HSEL[i] & mst_HTRANS[i*2+1];
    end
  end

  // Address-phase mux of the current owner; master 0 is the fallback selection
  always_comb begin
    own_sel   = mst_HSEL[0];
    own_addr  = mst_HADDR[0 +: HADDR_SIZE];
    own_write = mst_HWRITE[0];
    own_size  = mst_HSIZE[0 +: 3];
    own_burst = mst_HBURST[0 +: 3];
    own_prot  = mst_HPROT[0 +: 4];
    own_trans = mst_HTRANS[0 +: 2];
    own_lock  = mst_HMASTLOCK[0];
    for (int i = 1; i < MASTERS; i++) begin
      if (g_q == GW'(i)) begin
        own_sel   = mst_HSEL[i];
        own_addr  = mst_HADDR[i*HADDR_SIZE +: HADDR_SIZE];
        own_write = mst_HWRITE[i];
        own_size  = mst_HSIZE[i*3 +: 3];
        own_burst = mst_HBURST[i*3 +: 3];
        own_prot  = mst_HPROT[i*4 +: 4];
        own_trans = mst_HTRANS[i*2 +: 2];
        own_lock  = mst_HMASTLOCK[i];
      end
    end
  end

  // Data-phase write data follows the owner of the previous accepted address phase
  always_comb begin
    dph_wdata = mst_HWDATA[0 +: HDATA_SIZE];
    for (int i = 1; i < MASTERS; i++) begin
      if (d_q == GW'(i)) begin
        dph_wdata = mst_HWDATA[i*HDATA_SIZE +: HDATA_SIZE];
      end
    end
  end

  // Circular scan from owner+1; the owner itself is never a candidate, so no hit means parking
  always_comb begin
    logic found;
    int   idx;
    found      = 1'b0;
    idx        = 0;
    next_owner = g_q;
    other_req  = 1'b0;
    for (int k = 1; k < MASTERS; k++) begin
      idx = (int'(g_q) + k) % MASTERS;
      if (req[idx]) begin
        other_req = 1'b1;
        if (!found) begin
          next_owner = GW'(idx);
          found      = 1'b1;
        end
      end
    end
  end

  // Switch only when the owner has nothing in flight: ready bus, idle/deselected owner, no lock
  always_comb begin
    can_switch = HREADY & (~own_sel | (own_trans == 2'b00)) & ~own_lock;
    g_d        = can_switch ? next_owner : g_q;
    d_d        = HREADY ? g_q : d_q;
  end

  // Watchdog: count cycles the owner keeps the bus while someone else waits
  always_comb begin
    cnt_d = cnt_q;
    if ((g_d != g_q) || !other_req) begin
      cnt_d = 16'h0000;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'h0001;
    end
    timeout_d = timeout_q | (cnt_d == 16'(MAX_HOLD));
  end

  // Arbiter state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      g_q       <= '0;
      d_q       <= '0;
      cnt_q     <= 16'h0000;
      timeout_q <= 1'b0;
    end else begin
      g_q       <= g_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Per-master ready: only the owner sees the slave's HREADY, everyone is stalled in reset
  always_comb begin
    mst_HREADY = '0;
    for (int i = 0; i < MASTERS; i++) begin
      mst_HREADY[i] = HRESETn & HREADY & (g_q == GW'(i));
    end
  end

  // Slave-side outputs; control qualifiers are forced inactive while reset is held
  always_comb begin
    HSEL      = HRESETn & own_sel;
    HTRANS    = HRESETn ? own_trans : 2'b00;
    HMASTLOCK = HRESETn & own_lock;
    HADDR     = own_addr;
    HWRITE    = own_write;
    HSIZE     = own_size;
    HBURST    = own_burst;
    HPROT     = own_prot;
    HWDATA    = dph_wdata;
  end

  // Response path is shared by all masters
  always_comb begin
    mst_HRDATA  = HRDATA;
    mst_HRESP   = HRESP;
    arb_grant   = g_q;
    arb_timeout = timeout_q;
  end

endmodule

// File: doc/peripheral_arbiter_master_ahb3.md
Name: peripheral_arbiter_master_ahb3

Overview:
- Shares one AHB3-Lite slave-facing master port between MASTERS requesting AHB-Lite masters, for example DMA channels and the CPU BFM.
- Round-robin arbitration with grant changes only at legal transfer boundaries.
- Honours HMASTLOCK and stalls non-granted masters via per-master HREADY.
- Includes a hold-time watchdog that flags grant monopolisation.

Parameters:
- MASTERS, 2, number of requesting masters (2..8).
- HADDR_SIZE, 16, address width.
- HDATA_SIZE, 32, data width.
- MAX_HOLD, 64, owner-hold cycles before timeout is flagged (1..65535).

Ports:
- HRESETn  in  1  asynchronous active-low reset
- HCLK  in  1  clock
- mst_HSEL  in  MASTERS  per-master select
- mst_HADDR  in  MASTERS*HADDR_SIZE  address, master i at [i*HADDR_SIZE+:HADDR_SIZE]
- mst_HWDATA  in  MASTERS*HDATA_SIZE  write data, same packing
- mst_HWRITE  in  MASTERS  write enable
- mst_HSIZE  in  MASTERS*3  transfer size
- mst_HBURST  in  MASTERS*3  burst type
- mst_HPROT  in  MASTERS*4  protection
- mst_HTRANS  in  MASTERS*2  transfer type
- mst_HMASTLOCK  in  MASTERS  locked sequence
- mst_HREADY  out  MASTERS  per-master ready
- mst_HRDATA  out  HDATA_SIZE  read data, broadcast to all masters
- mst_HRESP  out  1  response, broadcast to all masters
- HSEL  out  1  slave-side select
- HADDR  out  HADDR_SIZE  muxed address
- HWDATA  out  HDATA_SIZE  muxed write data
- HRDATA  in  HDATA_SIZE  slave read data
- HWRITE  out  1  muxed write
- HSIZE  out  3  muxed size
- HBURST  out  3  muxed burst
- HPROT  out  4  muxed protection
- HTRANS  out  2  muxed transfer type
- HMASTLOCK  out  1  muxed lock
- HREADY  in  1  slave ready
- HRESP  in  1  slave response
- arb_grant  out  $clog2(MASTERS)  current owner index
- arb_timeout  out  1  sticky watchdog flag

Behaviour:

Requests and muxing:
- req[i] = mst_HSEL[i] & mst_HTRANS[i][1] (NONSEQ or SEQ).
- Registered grant g. Address-phase outputs (HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK) are combinational mux of master g.
- HWDATA is muxed from registered data-phase owner d. d <= g on every edge with HREADY=1.

Per-master ready:
- mst_HREADY[i] = HREADY when i==g, otherwise 0. Non-granted masters therefore hold their address phase.
- mst_HRDATA = HRDATA; mst_HRESP = HRESP.

Arbitration edge:
- Occurs on posedge HCLK when all of the following hold:
  - HREADY=1;
  - owner presents IDLE or has mst_HSEL[g]=0;
  - mst_HMASTLOCK[g]=0.
- New g is the first requester scanning circularly from g+1. If no other master requests, g is unchanged (parking).
- Because the switch only occurs while the owner presents IDLE, the owner has no pending data phase after the switch. No transfer is lost or duplicated.

Locking:
- While owner asserts HMASTLOCK, no switch occurs, even on IDLE.
- First edge with lock low that meets the other conditions is eligible to switch.

Bursts:
- SEQ/BUSY from owner never permits a switch.
- INCR bursts hold the grant until the owner goes IDLE.

Watchdog:
- 16-bit hold counter clears on every grant change or when no other master requests.
- Otherwise it increments each cycle, saturating at 0xFFFF.
- When the counter reaches MAX_HOLD, arb_timeout sets and stays set until reset. Arbitration itself is unaffected.

Reset (HRESETn=0, asynchronous):
- g=0, d=0, counter=0, arb_timeout=0, arb_grant=0.
- Slave-side HSEL=0, HTRANS=IDLE, HMASTLOCK=0 forced while in reset; other muxed outputs follow master 0.
- mst_HREADY=0 for all masters.
- Deassertion is synchronised by users. The first edge after release is a normal arbitration edge.

Simultaneous events:
- Requests arriving on the same edge as a switch are resolved purely by circular priority from the old g.
- Reset mid-burst abandons the burst. Slave HTRANS becomes IDLE immediately.

Test Plan:
1. Reset, then m0 and m1 both request NONSEQ single writes to 0x0010/0x0020, HREADY=1 → m0 transfer completes first; m0 then presents IDLE; g→1; HADDR=0x0020 next cycle; mst_HREADY[1] low until granted.
2. m0 issues INCR4 from 0x0100 while m1 requests → four beats 0x0100..0x010C complete uninterrupted; grant to m1 only at the edge after m0's IDLE; m1 never sees HREADY=1 before that.
3. m0 holds HMASTLOCK=1 across two singles with an IDLE between them, m1 requesting → no switch at the IDLE; switch at first IDLE with lock=0.
4. Slave inserts 3 wait states (HREADY=0) on m1 read of 0xBEEF0000 → mst_HRDATA=0xBEEF0000 is sampled by m1 on the ready edge; grant is not changed during the waits; HWDATA stays sourced from d.
5. MAX_HOLD=8, m0 issues INCR for 12 beats while m1 requests → arb_timeout rises in cycle 8 of contention and stays 1 after m0 releases.
6. Assert HRESETn=0 mid-WRAP8 of m1 → HTRANS=IDLE and HSEL=0 immediately; after release arb_grant=0 and arb_timeout=0.
